rc_iota_gen: RTL and testbench

RC_IOTA_GEN -- requirements
Module: rc_iota_gen

---
 rtl/keccak_pkg.sv | 24 ++
 rtl/rc_lfsr8.sv | 22 ++
 rtl/rc_iota_gen.sv | 170 +++++++++++++++++
 tb/tb_rc_iota_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak iota round-constant generator.
//   NUM_ROUNDS : default number of valid Keccak-f[1600] round indices
//   RC_SEED    : LFSR state for t = 0
//   RC_TAPS    : feedback pattern XORed in when the bit shifted out is 1
//   rc_state_e : controller states
//   rc_bit_pos : lane bit position (2^j - 1) written by rc bit j of a round
package keccak_pkg;

  localparam int unsigned NUM_ROUNDS = 24;
  localparam logic [7:0]  RC_SEED    = 8'h01;
  localparam logic [7:0]  RC_TAPS    = 8'h71;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_GEN,
    ST_DONE
  } rc_state_e;

  function automatic logic [5:0] rc_bit_pos(input logic [2:0] j);
    return 6'((7'd1 << j) - 7'd1);
  endfunction

endpackage

// File: rtl/rc_lfsr8.sv
// One step of the 8-bit round-constant LFSR (taps 0,4,5,6), purely combinational.
//   r_cur  : current LFSR state R
//   r_next : state after one step
//   rc_bit : rc(t) for the current state, i.e. R[0]
module rc_lfsr8
  import keccak_pkg::*;
(
  input  logic [7:0] r_cur,
  output logic [7:0] r_next,
  output logic       rc_bit
);

  always_comb begin
    r_next = {r_cur[6:0], 1'b0};
    if (r_cur[7]) begin
      r_next = r_next ^ RC_TAPS;
    end
  end

  assign rc_bit = r_cur[0];

endmodule

// File: rtl/rc_iota_gen.sv
// Keccak iota step: generates RC[round_idx] bit-serially from the rc LFSR and
// XORs it into lane A[0][0]. Consecutive round indices reuse the LFSR position
// left by the previous request, so they skip the seek phase.
//   clk       : clock
//   reset     : synchronous, active-low reset
//   start     : request pulse, only taken while idle
//   round_idx : round index of the request
//   lane_in   : lane A[0][0] before iota
//   busy      : request in progress (seek or generate)
//   done      : one-cycle pulse, err/rc_out/lane_out valid
//   err       : round_idx was out of range
//   rc_out    : round constant RC[round_idx]
//   lane_out  : lane_in XOR RC[round_idx]
//
// state | meaning
// IDLE  | waiting for start
// SEEK  | stepping the LFSR forward to t = 7*idx
// GEN   | collecting 7 rc bits into the constant
// DONE  | done pulse, results on the outputs
module rc_iota_gen #(
  parameter int unsigned NUM_ROUNDS = keccak_pkg::NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  round_idx,
  input  logic [63:0] lane_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rc_out,
  output logic [63:0] lane_out
);
  import keccak_pkg::*;

  rc_state_e   state_q, state_d;
  logic [7:0]  r_q, r_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] lane_q, lane_d;
  logic [63:0] acc_q, acc_d;
  logic [7:0]  seek_cnt_q, seek_cnt_d;
  logic [2:0]  gen_j_q, gen_j_d;
  logic        cache_vld_q, cache_vld_d;
  logic [4:0]  last_idx_q, last_idx_d;
  logic        err_q, err_d;
  logic [63:0] rc_out_q, rc_out_d;
  logic [63:0] lane_out_q, lane_out_d;

  logic [7:0]  r_next;
  logic        rc_bit;
  logic        idx_bad;
  logic        fast_path;

  rc_lfsr8 u_lfsr (
    .r_cur  (r_q),
    .r_next (r_next),
    .rc_bit (rc_bit)
  );

  assign idx_bad   = (32'(round_idx) >= NUM_ROUNDS);
  // After finishing round k the LFSR sits at t = 7*(k+1), exactly where round k+1 starts.
  assign fast_path = cache_vld_q && ({1'b0, round_idx} == ({1'b0, last_idx_q} + 6'd1));

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    seek_cnt_d  = seek_cnt_q;
    gen_j_d     = gen_j_q;
    cache_vld_d = cache_vld_q;
    last_idx_d  = last_idx_q;
    err_d       = err_q;
    rc_out_d    = rc_out_q;
    lane_out_d  = lane_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = round_idx;
          lane_d  = lane_in;
          acc_d   = '0;
          gen_j_d = '0;
          if (idx_bad) begin
            state_d     = ST_DONE;
            err_d       = 1'b1;
            rc_out_d    = '0;
            lane_out_d  = lane_in;
            cache_vld_d = 1'b0;
          end else if (fast_path) begin
            state_d = ST_GEN;
          end else begin
            r_d        = RC_SEED;
            seek_cnt_d = 8'(round_idx) * 8'd7;
            state_d    = (round_idx == 5'd0) ? ST_GEN : ST_SEEK;
          end
        end
      end

      ST_SEEK: begin
        r_d        = r_next;
        seek_cnt_d = seek_cnt_q - 8'd1;
        if (seek_cnt_q == 8'd1) begin
          state_d = ST_GEN;
        end
      end

      ST_GEN: begin
        acc_d   = acc_q | (64'(rc_bit) << rc_bit_pos(gen_j_q));
        r_d     = r_next;
        gen_j_d = gen_j_q + 3'd1;
        if (gen_j_q == 3'd6) begin
          // Results are loaded on the way into DONE so they are valid with done.
          state_d    = ST_DONE;
          err_d      = 1'b0;
          rc_out_d   = acc_d;
          lane_out_d = lane_q ^ acc_d;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!err_q) begin
          cache_vld_d = 1'b1;
          last_idx_d  = idx_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      r_q         <= RC_SEED;
      idx_q       <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      seek_cnt_q  <= '0;
      gen_j_q     <= '0;
      cache_vld_q <= 1'b0;
      last_idx_q  <= '0;
      err_q       <= 1'b0;
      rc_out_q    <= '0;
      lane_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      seek_cnt_q  <= seek_cnt_d;
      gen_j_q     <= gen_j_d;
      cache_vld_q <= cache_vld_d;
      last_idx_q  <= last_idx_d;
      err_q       <= err_d;
      rc_out_q    <= rc_out_d;
      lane_out_q  <= lane_out_d;
    end
  end

  assign busy     = (state_q == ST_SEEK) || (state_q == ST_GEN);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign rc_out   = rc_out_q;
  assign lane_out = lane_out_q;

endmodule

// File: tb/tb_rc_iota_gen.sv
module tb_rc_iota_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  round_idx;
  logic [63:0] lane_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rc_out;
  logic [63:0] lane_out;

  rc_iota_gen #(.NUM_ROUNDS(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .round_idx (round_idx),
    .lane_in   (lane_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rc_out    (rc_out),
    .lane_out  (lane_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic        err;
    logic [63:0] rc;
    logic [63:0] lane;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b0;

  // Reference: rc(t) sequence and per-round constants from the LFSR definition.
  logic        rc_t [0:254];
  logic [63:0] rc_tab [0:31];
  logic        mdl_valid;
  logic [4:0]  mdl_last;

  logic [63:0] hold_rc, hold_lane;
  logic        hold_err;

  initial begin
    logic [7:0] r;
    r = 8'h01;
    for (int t = 0; t < 255; t++) begin
      rc_t[t] = r[0];
      r = (r[7]) ? ((r << 1) ^ 8'h71) : (r << 1);
    end
    for (int ir = 0; ir < 32; ir++) begin
      rc_tab[ir] = '0;
      if (ir < 24)
        for (int j = 0; j < 7; j++) rc_tab[ir][(2 ** j) - 1] = rc_t[7 * ir + j];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_at_edge = reset;
  end

  // Monitor: pops one expectation per done, otherwise checks that outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      hold_rc   = '0;
      hold_lane = '0;
      hold_err  = 1'b0;
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rc_out", rc_out, e.rc);
        chk("lane_out", lane_out, e.lane);
        chk("err", 64'(err), 64'(e.err));
        chk("latency_cycle", 64'(cyc), 64'(e.exp_cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
        if (!e.err) begin
          case (e.idx)
            5'd0:  chk("rc_const_0", rc_out, 64'h0000000000000001);
            5'd1:  chk("rc_const_1", rc_out, 64'h0000000000008082);
            5'd2:  chk("rc_const_2", rc_out, 64'h800000000000808A);
            5'd23: chk("rc_const_23", rc_out, 64'h8000000080008008);
            default: ;
          endcase
        end
      end
      hold_rc   = rc_out;
      hold_lane = lane_out;
      hold_err  = err;
    end else begin
      chk("hold_rc", rc_out, hold_rc);
      chk("hold_lane", lane_out, hold_lane);
      chk("hold_err", 64'(err), 64'(hold_err));
    end
  end

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b0;
    sb.delete();
    mdl_valid = 1'b0;
    mdl_last  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("busy_after_reset", 64'(busy), 64'd0);
    chk("done_after_reset", 64'(done), 64'd0);
    chk("rc_after_reset", rc_out, 64'd0);
    chk("lane_after_reset", lane_out, 64'd0);
    chk("err_after_reset", 64'(err), 64'd0);
  endtask

  // Called at a negedge with the DUT idle; start is sampled on the next posedge.
  task automatic issue(input logic [4:0] idx, input logic [63:0] lane);
    exp_t e;
    int   s;
    e.idx = idx;
    if (idx >= 5'd24) begin
      e.err     = 1'b1;
      e.rc      = '0;
      e.lane    = lane;
      e.exp_cyc = cyc + 1;
      mdl_valid = 1'b0;
    end else begin
      s = (mdl_valid && (int'(idx) == int'(mdl_last) + 1)) ? 0 : int'(idx);
      e.err     = 1'b0;
      e.rc      = rc_tab[idx];
      e.lane    = lane ^ rc_tab[idx];
      e.exp_cyc = cyc + 1 + 7 * s + 7;
      mdl_valid = 1'b1;
      mdl_last  = idx;
    end
    sb.push_back(e);
    start     = 1'b1;
    round_idx = idx;
    lane_in   = lane;
    @(negedge clk);
    start     = 1'b0;
    round_idx = 5'($urandom);
    lane_in   = {$urandom, $urandom};
  endtask

  task automatic pulse_ignored(input logic [4:0] idx);
    start     = 1'b1;
    round_idx = idx;
    lane_in   = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] idx;
    reset     = 1'b0;
    start     = 1'b0;
    round_idx = '0;
    lane_in   = '0;
    hold_rc   = '0;
    hold_lane = '0;
    hold_err  = 1'b0;
    @(negedge clk);
    do_reset();

    issue(5'd0, 64'd0);
    wait_idle();

    do_reset();
    issue(5'd1, 64'hFFFFFFFFFFFFFFFF);
    wait_idle();

    do_reset();
    for (int i = 0; i < 24; i++) begin
      issue(5'(i), 64'd0);
      wait_idle();
    end

    do_reset();
    issue(5'd23, 64'h0123456789ABCDEF);
    repeat (30) @(negedge clk);
    pulse_ignored(5'd5);
    wait_idle();

    issue(5'd24, 64'h1234);
    wait_idle();
    issue(5'd25, 64'h5678);
    wait_idle();
    issue(5'd1, 64'hA5A5A5A5A5A5A5A5);
    wait_idle();

    issue(5'd10, 64'hDEADBEEF);
    repeat (20) @(negedge clk);
    do_reset();
    repeat (80) @(negedge clk);
    issue(5'd0, 64'd0);
    wait_idle();

    idx = 5'd0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1 && idx < 5'd23) idx = idx + 5'd1;
      else idx = 5'($urandom_range(0, 27));
      issue(idx, {$urandom, $urandom});
      if (idx < 5'd24 && $urandom_range(0, 3) == 0) pulse_ignored(5'($urandom));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
